alu_cmd_sequencer: RTL and testbench

// - Upstream issue stage for the 4-bit combinational alu block.
// - Buffers {opcode, a, b, tag} commands in a small FIFO and issues them one at a time.
// - Drives the ALU operand/opcode inputs from registers and captures the ALU result.
// - Returns each result on a valid/ready response port, tagged, in issue order.

---
 rtl/alu_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command FIFO plus IDLE/EXEC/RESP issue FSM in front of a
// combinational 4-bit ALU. Commands are issued one at a time, the ALU result
// is captured one cycle after issue, and it is returned tagged, in order.
// Optional feature macro: ALU_DIVZERO_CHECK_EN (flags div with b==0, forces
// rsp_data to 4'hF and raises rsp_err). When undefined, rsp_err is tied low.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,   // power of 2, >= 2
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0]       opcode;
    logic [3:0]       a;
    logic [3:0]       b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  cmd_t            mem [DEPTH];
  cmd_t            head;
  cmd_t            wr_cmd;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            empty, push, pop;
  state_t          state;
  logic [TAG_W-1:0] tag_q;
`ifdef ALU_DIVZERO_CHECK_EN
  logic            div0_q;
`endif

  assign empty     = (count == '0);
  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even when the FSM pops in the same cycle.
  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  // In RESP rsp_valid is always high, so rsp_ready alone completes the handshake.
  assign pop       = !empty && ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;
  assign wr_cmd    = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, tag: cmd_tag};

  // FIFO storage: data only, never reset (occupancy is tracked by count).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_cmd;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue registers: load the FIFO head on every pop, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      tag_q      <= '0;
`ifdef ALU_DIVZERO_CHECK_EN
      div0_q     <= 1'b0;
`endif
    end else if (pop) begin
      alu_opcode <= head.opcode;
      alu_a      <= head.a;
      alu_b      <= head.b;
      tag_q      <= head.tag;
`ifdef ALU_DIVZERO_CHECK_EN
      div0_q     <= (head.opcode == 4'd4) && (head.b == 4'd0);
`endif
    end
  end

`ifndef ALU_DIVZERO_CHECK_EN
  assign rsp_err = 1'b0;
`endif

  // Issue FSM: capture the ALU result in EXEC, hold the response in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
`ifdef ALU_DIVZERO_CHECK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) state <= EXEC;
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_tag   <= tag_q;
`ifdef ALU_DIVZERO_CHECK_EN
          rsp_data  <= div0_q ? 4'hF : alu_c;
          rsp_err   <= div0_q;
`else
          rsp_data  <= alu_c;
`endif
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= pop ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a behavioural ALU drives alu_c,
// and a queue of expected responses (computed from the command fields) is
// checked on every response handshake. Directed steps cover latency, wrap,
// div-by-zero, invalid opcode, backpressure and reset mid-operation, followed
// by a randomized traffic phase.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_opcode, cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic [3:0]       alu_opcode, alu_a, alu_b, alu_c;
  logic             rsp_valid, rsp_ready, rsp_err, busy;
  logic [3:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  typedef struct {
    logic [3:0]       data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   accepted;
  logic hold_pend = 1'b0;
  logic [15:0] held;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU; division by zero returns 0.
  function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (op)
      4'd1:    r = ai + bi;
      4'd2:    r = ai - bi + 16;
      4'd3:    r = ai * bi;
      4'd4:    r = (bi == 0) ? 0 : ai / bi;
      4'd5:    r = ai & bi;
      4'd6:    r = ai ^ bi;
      4'd7:    r = 15 - ai;
      4'd8:    r = ai | bi;
      default: r = 0;
    endcase
    return 4'(r % 16);
  endfunction

  assign alu_c = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Sample handshakes in the low phase, then advance one clock.
  task automatic tick();
    exp_t e;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 16'(rsp_valid), 16'd1);
        check("hold_payload", {9'd0, rsp_err, 2'(rsp_tag), rsp_data}, held);
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) check("stale_rsp", 16'(rsp_valid), 16'd0);
        else begin
          e = q.pop_front();
          check("rsp_data", 16'(rsp_data), 16'(e.data));
          check("rsp_tag", 16'(rsp_tag), 16'(e.tag));
          check("rsp_err", 16'(rsp_err), 16'(e.err));
        end
      end
      if (cmd_valid && cmd_ready) begin
        e.data = alu_fn(cmd_opcode, cmd_a, cmd_b);
        e.tag  = cmd_tag;
        e.err  = 1'b0;
`ifdef ALU_DIVZERO_CHECK_EN
        if (cmd_opcode == 4'd4 && cmd_b == 4'd0) begin
          e.data = 4'hF;
          e.err  = 1'b1;
        end
`endif
        q.push_back(e);
        accepted++;
      end
      hold_pend = rsp_valid && !rsp_ready;
      held = {9'd0, rsp_err, 2'(rsp_tag), rsp_data};
    end
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic v, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [TAG_W-1:0] t);
    cmd_valid = v; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = t;
  endtask

  task automatic drain(input string name);
    int n = 0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    while ((q.size() > 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check(name, 16'(q.size()), 16'd0);
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    set_cmd(1'b0, 4'd0, 4'd0, 4'd0, '0);
    @(negedge clk);
    tick(); tick();
    // Reset state
    check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    check("rst_cmd_ready", 16'(cmd_ready), 16'd1);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_alu", {4'd0, alu_opcode, alu_a, alu_b}, 16'd0);
    check("rst_rsp", {9'd0, rsp_err, 2'(rsp_tag), rsp_data}, 16'd0);
    rst = 1'b0;
    tick();

    // Add with latency: accepted at edge k, valid after edge k+2
    rsp_ready = 1'b1;
    set_cmd(1'b1, 4'd1, 4'd3, 4'd5, 2'd1);
    tick();
    cmd_valid = 1'b0;
    check("add_lat_k", 16'(rsp_valid), 16'd0);
    tick();
    check("add_lat_k1", 16'(rsp_valid), 16'd0);
    check("add_issue", {4'd0, alu_opcode, alu_a, alu_b}, 16'h0135);
    check("add_busy", 16'(busy), 16'd1);
    tick();
    check("add_lat_k2", 16'(rsp_valid), 16'd1);
    check("add_data", {2'(rsp_tag), rsp_data}, {2'd1, 4'h8});
    tick(); tick();
    check("add_idle_busy", 16'(busy), 16'd0);

    // Wrap: sub and mul back-to-back
    set_cmd(1'b1, 4'd2, 4'd2, 4'd5, 2'd2); tick();
    set_cmd(1'b1, 4'd3, 4'd6, 4'd3, 2'd3); tick();
    drain("wrap_drain");

    // Divide by zero, then invalid opcode
    set_cmd(1'b1, 4'd4, 4'd9, 4'd0, 2'd0); tick();
    cmd_valid = 1'b0;
    tick(); tick();
`ifdef ALU_DIVZERO_CHECK_EN
    check("div0_data", {7'd0, rsp_err, rsp_data}, {7'd0, 1'b1, 4'hF});
`else
    check("div0_data", {7'd0, rsp_err, rsp_data}, {7'd0, 1'b0, alu_fn(4'd4, 4'd9, 4'd0)});
`endif
    drain("div0_drain");
    set_cmd(1'b1, 4'd0, 4'hF, 4'hF, 2'd3); tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check("inv_data", {2'(rsp_tag), rsp_data}, {2'd3, 4'h0});
    drain("inv_drain");

    // Backpressure: 6 offered, 5 accepted
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      set_cmd(1'b1, 4'(1 + i), 4'(i + 7), 4'(i + 1), 2'(i));
      tick();
    end
    check("bp_accepted", 16'(accepted), 16'd5);
    check("bp_cmd_ready", 16'(cmd_ready), 16'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_ready_rise", 16'(cmd_ready), 16'd1);
    drain("bp_drain");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drain");

    // Reset while in RESP with 3 queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, 4'd6, 4'(i), 4'hA, 2'(i));
      tick();
    end
    cmd_valid = 1'b0;
    check("mid_rsp_valid", 16'(rsp_valid), 16'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 16'(rsp_valid), 16'd0);
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_ready", 16'(cmd_ready), 16'd1);
    check("mid_rst_alu", {4'd0, alu_opcode, alu_a, alu_b}, 16'd0);
    q.delete();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_valid", 16'(rsp_valid), 16'd0);
    check("post_rst_busy", 16'(busy), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: all loops are bounded, this only guards against a stuck clock.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
